// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
package pipe_pkg;

   // Register $0 is hard-wired to zero and never carries a dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Default width of the stall/flush performance counters.
   localparam int CNT_W_DEFAULT = 32;

   // Sequencer states: normal issue, or holding the front end flushed after a redirect.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_REDIRECT = 1'b1
   } seq_state_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one ID-stage source operand against the EX and MEM destinations
// and flags a dependency that forwarding cannot cover.
module hazard_match
   import pipe_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  logic [4:0] src,
   input  logic       use_src,
   input  logic [4:0] dest_ex,
   input  logic       reg_write_ex,
   input  logic       mem_read_ex,
   input  logic [4:0] dest_mem,
   input  logic       reg_write_mem,
   output logic       hit
);

   // With EX/MEM forwarding only a load in EX is too late; without it any
   // in-flight producer in EX or MEM must drain first.
   localparam logic FWD = (FWD_EN != 0);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = reg_write_ex && (dest_ex == src) && (mem_read_ex || !FWD);
   assign mem_hit = !FWD && reg_write_mem && (dest_mem == src);
   assign hit     = use_src && (src != REG_ZERO) && (ex_hit || mem_hit);

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage core: stalls on unresolved RAW hazards,
// flushes and holds the front end after a MEM-stage redirect, and counts
// stall cycles and accepted redirects.
module hazard_sequencer
   import pipe_pkg::*;
#(
   parameter int FWD_EN          = 1,
   parameter int REDIRECT_CYCLES = 1,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic             use_rs_id,
   input  logic             use_rt_id,
   input  logic [4:0]       dest_ex,
   input  logic             RegWrite_ex,
   input  logic             MemRead_ex,
   input  logic [4:0]       dest_mem,
   input  logic             RegWrite_mem,
   input  logic             redirect_mem,
   output logic             PCWrite,
   output logic             IF_IDWrite,
   output logic             ID_EXWrite,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Cycles remaining in REDIRECT after the redirect cycle itself.
   localparam logic [2:0] RED_INIT = 3'(REDIRECT_CYCLES - 1);

   seq_state_t state, state_nxt;
   logic [2:0] red_left, red_left_nxt;
   logic       hz_a, hz_b, hazard;
   logic       stall_inc, flush_inc;

   hazard_match #(.FWD_EN(FWD_EN)) u_match_rs (
      .src          (rs_id),
      .use_src      (use_rs_id),
      .dest_ex      (dest_ex),
      .reg_write_ex (RegWrite_ex),
      .mem_read_ex  (MemRead_ex),
      .dest_mem     (dest_mem),
      .reg_write_mem(RegWrite_mem),
      .hit          (hz_a)
   );

   hazard_match #(.FWD_EN(FWD_EN)) u_match_rt (
      .src          (rt_id),
      .use_src      (use_rt_id),
      .dest_ex      (dest_ex),
      .reg_write_ex (RegWrite_ex),
      .mem_read_ex  (MemRead_ex),
      .dest_mem     (dest_mem),
      .reg_write_mem(RegWrite_mem),
      .hit          (hz_b)
   );

   assign hazard = hz_a || hz_b;

   // Next-state, counter enables and pipeline control; redirect beats hazard, reset beats all.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_nxt    = state;
      red_left_nxt = red_left;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      PCWrite      = 1'b1;
      IF_IDWrite   = 1'b1;
      ID_EXWrite   = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      flush_exmem  = 1'b0;

      if (redirect_mem) begin
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
         flush_inc   = 1'b1;
         if (REDIRECT_CYCLES > 1) begin
            state_nxt    = ST_REDIRECT;
            red_left_nxt = RED_INIT;
         end else begin
            state_nxt    = ST_RUN;
            red_left_nxt = 3'd0;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (hazard) begin
                  PCWrite    = 1'b0;
                  IF_IDWrite = 1'b0;
                  ID_EXWrite = 1'b1;
                  stall_inc  = 1'b1;
               end
            end
            ST_REDIRECT: begin
               flush_ifid   = 1'b1;
               flush_idex   = 1'b1;
               red_left_nxt = red_left - 3'd1;
               if (red_left <= 3'd1) begin
                  state_nxt    = ST_RUN;
                  red_left_nxt = 3'd0;
               end
            end
            default: begin
               state_nxt    = ST_RUN;
               red_left_nxt = 3'd0;
            end
         endcase
      end

      if (Reset) begin
         PCWrite     = 1'b0;
         IF_IDWrite  = 1'b0;
         ID_EXWrite  = 1'b1;
         flush_ifid  = 1'b0;
         flush_idex  = 1'b0;
         flush_exmem = 1'b0;
      end
   end

   // State, redirect countdown and saturating counters.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Reset) begin
         state     <= ST_RUN;
         red_left  <= 3'd0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         red_left <= red_left_nxt;
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: three parameterisations share one
// stimulus stream (forwarding with 3-cycle redirect, no forwarding with
// 1-cycle redirect, and 2-bit counters for saturation).
module tb_hazard_sequencer;

   // Control vector order: {PCWrite, IF_IDWrite, ID_EXWrite, flush_ifid, flush_idex, flush_exmem}
   localparam logic [5:0] CTL_RUN   = 6'b110000;
   localparam logic [5:0] CTL_STALL = 6'b001000;
   localparam logic [5:0] CTL_RESET = 6'b001000;
   localparam logic [5:0] CTL_REDIR = 6'b110111;
   localparam logic [5:0] CTL_HOLD  = 6'b100110;
   localparam logic [5:0] MSK_HOLD  = 6'b101111;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [4:0] rs_id, rt_id, dest_ex, dest_mem;
   logic       use_rs_id, use_rt_id, RegWrite_ex, MemRead_ex, RegWrite_mem, redirect_mem;

   logic        pc_a, ifid_a, idex_a, fi_a, fx_a, fm_a;
   logic        pc_b, ifid_b, idex_b, fi_b, fx_b, fm_b;
   logic        pc_c, ifid_c, idex_c, fi_c, fx_c, fm_c;
   logic [31:0] stall_a, flush_a, stall_b, flush_b;
   logic [1:0]  stall_c, flush_c;
   logic [5:0]  ctl_a, ctl_b;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   hazard_sequencer #(.FWD_EN(1), .REDIRECT_CYCLES(3), .CNT_W(32)) dut_a (
      .Clk(Clk), .Reset(Reset), .rs_id(rs_id), .rt_id(rt_id),
      .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .dest_ex(dest_ex),
      .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .dest_mem(dest_mem),
      .RegWrite_mem(RegWrite_mem), .redirect_mem(redirect_mem),
      .PCWrite(pc_a), .IF_IDWrite(ifid_a), .ID_EXWrite(idex_a),
      .flush_ifid(fi_a), .flush_idex(fx_a), .flush_exmem(fm_a),
      .stall_cnt(stall_a), .flush_cnt(flush_a)
   );

   hazard_sequencer #(.FWD_EN(0), .REDIRECT_CYCLES(1), .CNT_W(32)) dut_b (
      .Clk(Clk), .Reset(Reset), .rs_id(rs_id), .rt_id(rt_id),
      .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .dest_ex(dest_ex),
      .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .dest_mem(dest_mem),
      .RegWrite_mem(RegWrite_mem), .redirect_mem(redirect_mem),
      .PCWrite(pc_b), .IF_IDWrite(ifid_b), .ID_EXWrite(idex_b),
      .flush_ifid(fi_b), .flush_idex(fx_b), .flush_exmem(fm_b),
      .stall_cnt(stall_b), .flush_cnt(flush_b)
   );

   hazard_sequencer #(.FWD_EN(1), .REDIRECT_CYCLES(3), .CNT_W(2)) dut_c (
      .Clk(Clk), .Reset(Reset), .rs_id(rs_id), .rt_id(rt_id),
      .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .dest_ex(dest_ex),
      .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .dest_mem(dest_mem),
      .RegWrite_mem(RegWrite_mem), .redirect_mem(redirect_mem),
      .PCWrite(pc_c), .IF_IDWrite(ifid_c), .ID_EXWrite(idex_c),
      .flush_ifid(fi_c), .flush_idex(fx_c), .flush_exmem(fm_c),
      .stall_cnt(stall_c), .flush_cnt(flush_c)
   );

   assign ctl_a = {pc_a, ifid_a, idex_a, fi_a, fx_a, fm_a};
   assign ctl_b = {pc_b, ifid_b, idex_b, fi_b, fx_b, fm_b};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive all ID/EX/MEM inputs in one call.
   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] dex, input logic rwex,
                        input logic mrex, input logic [4:0] dmem, input logic rwmem,
                        input logic redir);
      rs_id = rs; rt_id = rt; use_rs_id = urs; use_rt_id = urt;
      dest_ex = dex; RegWrite_ex = rwex; MemRead_ex = mrex;
      dest_mem = dmem; RegWrite_mem = rwmem; redirect_mem = redir;
      #2;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic load_use_rs5(input logic redir);
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, redir);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      idle();
      check("reset_ctl", 32'(ctl_a), 32'(CTL_RESET));
      cyc();
      cyc();
      Reset = 1'b0;
      idle();
      check("reset_stall", stall_a, 0);
      check("reset_flush", flush_a, 0);
      check("idle_run_a", 32'(ctl_a), 32'(CTL_RUN));
      check("idle_run_b", 32'(ctl_b), 32'(CTL_RUN));
      cyc();

      // Load-use on rs: both variants stall; only the no-forward one keeps stalling on an ALU producer.
      load_use_rs5(1'b0);
      check("lu_stall_a", 32'(ctl_a), 32'(CTL_STALL));
      check("lu_stall_b", 32'(ctl_b), 32'(CTL_STALL));
      cyc();
      check("lu_cnt_a", stall_a, 1);
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      check("alu_fwd_run_a", 32'(ctl_a), 32'(CTL_RUN));
      check("alu_nofwd_stall_b", 32'(ctl_b), 32'(CTL_STALL));
      cyc();
      check("alu_cnt_a", stall_a, 1);
      check("alu_cnt_b", stall_b, 2);

      // $0 destination and unused operand never stall.
      drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      check("zero_reg_a", 32'(ctl_a), 32'(CTL_RUN));
      check("zero_reg_b", 32'(ctl_b), 32'(CTL_RUN));
      cyc();
      drive(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      check("unused_rt_a", 32'(ctl_a), 32'(CTL_RUN));
      check("unused_rt_b", 32'(ctl_b), 32'(CTL_RUN));
      cyc();
      check("zero_cnt_a", stall_a, 1);
      check("zero_cnt_b", stall_b, 2);

      // RAW through MEM on rt: stalls only without forwarding.
      drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      check("mem_raw_b", 32'(ctl_b), 32'(CTL_STALL));
      check("mem_raw_a", 32'(ctl_a), 32'(CTL_RUN));
      cyc();
      check("mem_raw_cnt_b", stall_b, 3);
      check("mem_raw_cnt_a", stall_a, 1);

      // Redirect overrides a load-use stall, then the 3-cycle hold ignores hazards.
      load_use_rs5(1'b1);
      check("redir_ctl_a", 32'(ctl_a), 32'(CTL_REDIR));
      check("redir_ctl_b", 32'(ctl_b), 32'(CTL_REDIR));
      cyc();
      check("redir_flush_a", flush_a, 1);
      check("redir_stall_a", stall_a, 1);
      check("redir_stall_b", stall_b, 3);
      load_use_rs5(1'b0);
      check("hold1_a", 32'(ctl_a & MSK_HOLD), 32'(CTL_HOLD & MSK_HOLD));
      check("rc1_back_run_b", 32'(ctl_b), 32'(CTL_STALL));
      cyc();
      load_use_rs5(1'b0);
      check("hold2_a", 32'(ctl_a & MSK_HOLD), 32'(CTL_HOLD & MSK_HOLD));
      cyc();
      idle();
      check("hold_done_a", 32'(ctl_a), 32'(CTL_RUN));
      check("hold_nostall_a", stall_a, 1);
      check("hold_stall_b", stall_b, 5);
      cyc();

      // A second redirect during REDIRECT restarts the hold.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("ext_t0_a", 32'(ctl_a), 32'(CTL_REDIR));
      cyc();
      check("ext_t1_a", 32'(ctl_a), 32'(CTL_REDIR));
      cyc();
      idle();
      check("ext_flush_a", flush_a, 3);
      check("ext_t2_a", 32'(ctl_a & MSK_HOLD), 32'(CTL_HOLD & MSK_HOLD));
      cyc();
      check("ext_t3_a", 32'(ctl_a & MSK_HOLD), 32'(CTL_HOLD & MSK_HOLD));
      cyc();
      check("ext_t4_a", 32'(ctl_a), 32'(CTL_RUN));
      cyc();

      // Three more stalls: the 2-bit counters pin at 3.
      for (int i = 0; i < 3; i++) begin
         load_use_rs5(1'b0);
         cyc();
      end
      check("sat_stall_a", stall_a, 4);
      check("sat_stall_c", 32'(stall_c), 3);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc();
      check("sat_flush_a", flush_a, 4);
      check("sat_flush_c", 32'(flush_c), 3);

      // Reset in the middle of REDIRECT with both counters at 4.
      Reset = 1'b1;
      idle();
      check("midreset_ctl_a", 32'(ctl_a), 32'(CTL_RESET));
      cyc();
      Reset = 1'b0;
      idle();
      check("post_reset_ctl_a", 32'(ctl_a), 32'(CTL_RUN));
      check("post_reset_stall_a", stall_a, 0);
      check("post_reset_flush_a", flush_a, 0);
      check("post_reset_stall_c", 32'(stall_c), 0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
